// File: rtl/bcd_countdown_mmss.sv
// Purpose : four-digit BCD MM:SS countdown timer with load, run/pause and optional wrap-reload.
// Latency : every output is registered; a tick, button or load shows on the outputs one clock later.
// Backpress: none; tick and buttons are single-cycle pulses, and they are dropped when the state ignores them.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   tick                : one-cycle 1 Hz enable; decrements only while running
//   start_pause         : one-pulse button; IDLE->RUN (if non-zero), RUN<->PAUSE
//   load                : one-pulse button; any state -> IDLE with clamped init digits
//   init_min1..init_sec0: switch-selected initial digits (clamped to valid BCD on load)
//   min1..sec0          : current MM:SS digits, BCD
//   running / done      : state flags (RUN / DONE)
//   borrow_min          : one-cycle pulse when the seconds field wraps from 00 to SEC1_MAX9

module bcd_countdown_mmss #(
    parameter int SEC1_MAX = 5,
    parameter int MIN1_MAX = 9,
    parameter bit WRAP     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_pause,
    input  logic       load,
    input  logic [3:0] init_min1,
    input  logic [3:0] init_min0,
    input  logic [3:0] init_sec1,
    input  logic [3:0] init_sec0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       running,
    output logic       done,
    output logic       borrow_min
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] SEC1_MAX_D = SEC1_MAX[3:0];
    localparam logic [3:0] MIN1_MAX_D = MIN1_MAX[3:0];
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    typedef struct packed {
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } mmss_t;

    logic [1:0] state_q, state_d;
    mmss_t      cnt_q, cnt_d;
    mmss_t      init_q, init_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       borrow_min_q, borrow_min_d;

    mmss_t      init_clamped;
    mmss_t      cnt_dec;
    logic       dec_borrow_sec;
    logic       cnt_is_zero;
    logic       dec_is_zero;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    // The tens limits are applied on top of the plain BCD limit so that a
    // tens maximum configured above 9 still never yields a non-BCD digit.
    always_comb begin
        init_clamped.min1 = clamp_digit(clamp_digit(init_min1, DIGIT_MAX), MIN1_MAX_D);
        init_clamped.min0 = clamp_digit(init_min0, DIGIT_MAX);
        init_clamped.sec1 = clamp_digit(clamp_digit(init_sec1, DIGIT_MAX), SEC1_MAX_D);
        init_clamped.sec0 = clamp_digit(init_sec0, DIGIT_MAX);
    end

    assign cnt_is_zero = (cnt_q == '0);

    // One-second decrement with the borrow rippling from sec0 up to min1.
    // min1 is never decremented below zero because 00:00 is never decremented.
    always_comb begin
        cnt_dec        = cnt_q;
        dec_borrow_sec = 1'b0;
        if (cnt_q.sec0 != 4'd0) begin
            cnt_dec.sec0 = cnt_q.sec0 - 4'd1;
        end else begin
            cnt_dec.sec0 = DIGIT_MAX;
            if (cnt_q.sec1 != 4'd0) begin
                cnt_dec.sec1 = cnt_q.sec1 - 4'd1;
            end else begin
                cnt_dec.sec1   = SEC1_MAX_D;
                dec_borrow_sec = 1'b1;
                if (cnt_q.min0 != 4'd0) begin
                    cnt_dec.min0 = cnt_q.min0 - 4'd1;
                end else begin
                    cnt_dec.min0 = DIGIT_MAX;
                    cnt_dec.min1 = cnt_q.min1 - 4'd1;
                end
            end
        end
    end

    assign dec_is_zero = (cnt_dec == '0);

    // Next-state logic. Priority is load > start_pause > tick; rst is applied
    // in the register block and overrides everything computed here.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_d       = init_q;
        borrow_min_d = 1'b0;

        if (load) begin
            state_d = ST_IDLE;
            cnt_d   = init_clamped;
            init_d  = init_clamped;
        end else if (start_pause) begin
            // A tick in the same cycle is deliberately dropped, so a pause
            // never costs a second and a resume never gains one.
            case (state_q)
                ST_IDLE:  if (!cnt_is_zero) state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (tick && (state_q == ST_RUN)) begin
            borrow_min_d = dec_borrow_sec;
            if (dec_is_zero) begin
                if (WRAP) begin
                    // Reaching zero reloads the stored start value and keeps running.
                    cnt_d = init_q;
                end else begin
                    cnt_d   = cnt_dec;
                    state_d = ST_DONE;
                end
            end else begin
                cnt_d = cnt_dec;
            end
        end
    end

    // Flags are decoded from the next state so they land on the same edge as the state.
    always_comb begin
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            init_q       <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            borrow_min_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_q       <= init_d;
            running_q    <= running_d;
            done_q       <= done_d;
            borrow_min_q <= borrow_min_d;
        end
    end

    assign min1       = cnt_q.min1;
    assign min0       = cnt_q.min0;
    assign sec1       = cnt_q.sec1;
    assign sec0       = cnt_q.sec0;
    assign running    = running_q;
    assign done       = done_q;
    assign borrow_min = borrow_min_q;

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
module tb_bcd_countdown_mmss;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] init_min1 = 4'd0;
    logic [3:0] init_min0 = 4'd0;
    logic [3:0] init_sec1 = 4'd0;
    logic [3:0] init_sec0 = 4'd0;

    logic [3:0] a_min1, a_min0, a_sec1, a_sec0;
    logic       a_running, a_done, a_borrow;
    logic [3:0] b_min1, b_min0, b_sec1, b_sec0;
    logic       b_running, b_done, b_borrow;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bcd_countdown_mmss #(.SEC1_MAX(5), .MIN1_MAX(9), .WRAP(1'b0)) u_stop (
        .clk(clk), .rst(rst), .tick(tick), .start_pause(start_pause), .load(load),
        .init_min1(init_min1), .init_min0(init_min0), .init_sec1(init_sec1), .init_sec0(init_sec0),
        .min1(a_min1), .min0(a_min0), .sec1(a_sec1), .sec0(a_sec0),
        .running(a_running), .done(a_done), .borrow_min(a_borrow)
    );

    bcd_countdown_mmss #(.SEC1_MAX(5), .MIN1_MAX(9), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .start_pause(start_pause), .load(load),
        .init_min1(init_min1), .init_min0(init_min0), .init_sec1(init_sec1), .init_sec0(init_sec0),
        .min1(b_min1), .min0(b_min0), .sec1(b_sec1), .sec0(b_sec0),
        .running(b_running), .done(b_done), .borrow_min(b_borrow)
    );

    // Reference model: the time is a plain number of seconds; index 0 stops, index 1 wraps.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int mv[2]    = '{0, 0};
    int ms[2]    = '{M_IDLE, M_IDLE};
    int minit[2] = '{0, 0};
    bit mb[2]    = '{1'b0, 1'b0};

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int init_secs();
        int m, s;
        m = lim(int'(init_min1), 9) * 10 + lim(int'(init_min0), 9);
        s = lim(int'(init_sec1), 5) * 10 + lim(int'(init_sec0), 9);
        return m * 60 + s;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int m, s;
        logic [15:0] r;
        m = v / 60;
        s = v % 60;
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(s / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mb[i] = 1'b0;
            if (rst) begin
                mv[i] = 0; ms[i] = M_IDLE; minit[i] = 0;
            end else if (load) begin
                mv[i] = init_secs(); minit[i] = mv[i]; ms[i] = M_IDLE;
            end else if (start_pause) begin
                if (ms[i] == M_IDLE && mv[i] != 0) ms[i] = M_RUN;
                else if (ms[i] == M_RUN)           ms[i] = M_PAUSE;
                else if (ms[i] == M_PAUSE)         ms[i] = M_RUN;
            end else if (tick && ms[i] == M_RUN) begin
                mb[i] = (mv[i] % 60 == 0);
                mv[i] = mv[i] - 1;
                if (mv[i] == 0) begin
                    if (i == 1) mv[i] = minit[i];
                    else        ms[i] = M_DONE;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [18:0] got, exp;
                logic [15:0] dg;
                if (i == 0) got = {a_min1, a_min0, a_sec1, a_sec0, a_running, a_done, a_borrow};
                else        got = {b_min1, b_min0, b_sec1, b_sec0, b_running, b_done, b_borrow};
                exp = {to_bcd(mv[i]), ms[i] == M_RUN, ms[i] == M_DONE, mb[i]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%h expected=%h", i, $time, got, exp);
                end
                dg = got[18:3];
                checks++;
                if (dg[15:12] > 4'd9 || dg[11:8] > 4'd9 || dg[7:4] > 4'd5 || dg[3:0] > 4'd9) begin
                    errors++;
                    $display("FAIL bcd_range inst%0d t=%0t got=%h expected digits within 9,9,5,9", i, $time, dg);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Inputs are applied for one posedge, then returned to idle at the following negedge.
    task automatic drive(input bit tk, input bit sp, input bit ld, input bit rs);
        tick = tk; start_pause = sp; load = ld; rst = rs;
        @(negedge clk);
        tick = 1'b0; start_pause = 1'b0; load = 1'b0; rst = 1'b0;
    endtask

    task automatic set_init(input logic [3:0] m1, input logic [3:0] m0,
                            input logic [3:0] s1, input logic [3:0] s0);
        init_min1 = m1; init_min0 = m0; init_sec1 = s1; init_sec0 = s0;
    endtask

    logic [15:0] a_dig, b_dig;
    assign a_dig = {a_min1, a_min0, a_sec1, a_sec0};
    assign b_dig = {b_min1, b_min0, b_sec1, b_sec0};

    initial begin
        @(negedge clk);
        drive(0, 0, 0, 1);
        chk_en = 1'b1;
        lit("reset_digits", 32'(a_dig), 32'h0000);
        lit("reset_flags", 32'({a_running, a_done, a_borrow}), 32'h0);

        // Load and run with a minute borrow.
        set_init(0, 1, 3, 0);
        drive(0, 0, 1, 0);
        lit("load_0130", 32'(a_dig), 32'h0130);
        drive(0, 1, 0, 0);
        lit("start_running", 32'(a_running), 32'h1);
        drive(1, 0, 0, 0);
        lit("first_tick_0129", 32'(a_dig), 32'h0129);
        for (int k = 0; k < 29; k++) drive(1, 0, 0, 0);
        lit("at_0100", 32'(a_dig), 32'h0100);
        lit("no_borrow_before", 32'(a_borrow), 32'h0);
        drive(1, 0, 0, 0);
        lit("borrow_0059", 32'({a_dig, 3'b000, a_borrow}), 32'h00591);
        drive(0, 0, 0, 0);
        lit("borrow_one_cycle", 32'(a_borrow), 32'h0);

        // Run to zero.
        set_init(0, 0, 0, 3);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        lit("zero_0002", 32'(a_dig), 32'h0002);
        drive(1, 0, 0, 0);
        lit("zero_0001", 32'(a_dig), 32'h0001);
        drive(1, 0, 0, 0);
        lit("zero_done", 32'({a_dig, 2'b00, a_running, a_done}), 32'h00001);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        lit("done_sticky", 32'({a_dig, 2'b00, a_running, a_done}), 32'h00001);
        drive(0, 0, 1, 0);
        lit("load_leaves_done", 32'({a_dig, 2'b00, a_running, a_done}), 32'h00030);

        // Pause / resume.
        set_init(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        lit("pause_0959", 32'(a_dig), 32'h0959);
        drive(1, 1, 0, 0);
        lit("pause_drops_tick", 32'({a_dig, 3'b000, a_running}), 32'h09590);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0);
        lit("paused_hold", 32'(a_dig), 32'h0959);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        lit("resume_0958", 32'(a_dig), 32'h0958);

        // Clamping and a full hour of borrows.
        set_init(4'hF, 4'h9, 4'h7, 4'hC);
        drive(0, 0, 1, 0);
        lit("clamp_9959", 32'(a_dig), 32'h9959);
        drive(0, 1, 0, 0);
        for (int k = 0; k < 3600; k++) drive(1, 0, 0, 0);
        lit("hour_3959", 32'(a_dig), 32'h3959);

        // Wrap instance reloads at zero.
        set_init(0, 0, 0, 2);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        lit("wrap_0001", 32'(b_dig), 32'h0001);
        drive(1, 0, 0, 0);
        lit("wrap_reload", 32'({b_dig, 2'b00, b_running, b_done}), 32'h00022);

        // Priorities.
        set_init(0, 0, 5, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        lit("prio_0049", 32'(a_dig), 32'h0049);
        drive(1, 0, 1, 0);
        lit("load_beats_tick", 32'({a_dig, 3'b000, a_running}), 32'h00500);
        drive(0, 0, 1, 1);
        lit("rst_beats_load", 32'({a_dig, 2'b00, a_running, a_done}), 32'h00000);
        set_init(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        lit("zero_start_ignored", 32'({a_dig, 3'b000, a_running}), 32'h00000);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int k = 0; k < 2500; k++) begin
            bit rs, ld, sp, tk;
            rs = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 59) == 0);
            sp = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 2) != 0);
            if (ld) begin
                if ($urandom_range(0, 1) == 1)
                    set_init(4'd0, 4'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                else
                    set_init(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
            drive(tk, sp, ld, rs);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
